// File: rtl/dram_cache_pkg.sv
// Shared widths and the request-log entry layout for the DRAM cache request front-end.
package dram_cache_pkg;

    localparam int ID_W       = 16;
    localparam int ADDR_W     = 64;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int ENTRY_W    = 1 + ID_W + ADDR_W;

    typedef struct packed {
        logic              is_write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } req_entry_t;

endpackage

// File: rtl/dram_cache_req_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module req_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = empty_q;
    assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dram_cache_top.sv
// Request front-end: arbitrates AR/AW into a request log and forwards reads through one register stage.
module dram_cache_top
    import dram_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ID_W-1:0]    arid_i,
    input  logic [ADDR_W-1:0]  araddr_i,
    input  logic [LEN_W-1:0]   arlen_i,
    input  logic               arvalid_i,
    output logic               arready_o,
    input  logic [ID_W-1:0]    awid_i,
    input  logic [ADDR_W-1:0]  awaddr_i,
    input  logic [LEN_W-1:0]   awlen_i,
    input  logic               awvalid_i,
    output logic               awready_o,
    output logic [ID_W-1:0]    arid_o,
    output logic [ADDR_W-1:0]  araddr_o,
    output logic [LEN_W-1:0]   arlen_o,
    output logic               arvalid_o,
    input  logic               arready_i,
    output logic               aempty_o,
    input  logic               rden_i,
    output logic [ENTRY_W-1:0] data_o
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // ready never depends on the matching valid, and a raised valid holds its payload
    // until that transfer happens.

    logic              arvalid_q, arvalid_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic              ar_acc, aw_acc;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    req_entry_t        push_entry;
    logic              awlen_unused;

    assign awlen_unused = ^awlen_i;

    always_comb begin
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;

        arready_o = (~arvalid_q | arready_i) & ~fifo_full;
        ar_acc    = arvalid_i & arready_o;
        // Reads win a same-cycle contest, so the log sees one push per cycle at most.
        awready_o = ~fifo_full & ~ar_acc;
        aw_acc    = awvalid_i & awready_o;
        fifo_push = ar_acc | aw_acc;

        if (ar_acc) begin
            arvalid_d = 1'b1;
            arid_d    = arid_i;
            araddr_d  = araddr_i;
            arlen_d   = arlen_i;
        end else if (arready_i) begin
            arvalid_d = 1'b0;
        end

        if (ar_acc) begin
            push_entry = '{is_write: 1'b0, id: arid_i, addr: araddr_i};
        end else begin
            push_entry = '{is_write: 1'b1, id: awid_i, addr: awaddr_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
        end
    end

    assign arvalid_o = arvalid_q;
    assign arid_o    = arid_q;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign aempty_o  = fifo_empty;

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .push_i  (fifo_push),
        .din_i   (push_entry),
        .pop_i   (rden_i),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .head_o  (data_o)
    );

endmodule

// File: tb/tb_dram_cache_top.sv
// Bench for dram_cache_top: directed scenarios with literal expectations plus a random run
// checked every cycle against a queue-based model of the request log and forward register.
module tb_dram_cache_top;

    localparam int EW = 81;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   arid_i, awid_i, arid_o;
    logic [63:0]   araddr_i, awaddr_i, araddr_o;
    logic [7:0]    arlen_i, awlen_i, arlen_o;
    logic          arvalid_i, arready_o, awvalid_i, awready_o;
    logic          arvalid_o, arready_i, aempty_o, rden_i;
    logic [EW-1:0] data_o;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: the logged requests in order, and the forwarded read.
    logic [EW-1:0] exp_q[$];
    logic          m_fv;
    logic [15:0]   m_id;
    logic [63:0]   m_addr;
    logic [7:0]    m_len;

    dram_cache_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arlen_i   (arlen_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .awid_i    (awid_i),
        .awaddr_i  (awaddr_i),
        .awlen_i   (awlen_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .arid_o    (arid_o),
        .araddr_o  (araddr_o),
        .arlen_o   (arlen_o),
        .arvalid_o (arvalid_o),
        .arready_i (arready_i),
        .aempty_o  (aempty_o),
        .rden_i    (rden_i),
        .data_o    (data_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare then advance the model by one clock.
    always @(negedge clk) begin
        logic          full, exp_arr, exp_awr, ar_acc, aw_acc;
        logic [EW-1:0] exp_head;
        if (rst_n) begin
            exp_q.delete();
            m_fv   = 1'b0;
            m_id   = '0;
            m_addr = '0;
            m_len  = '0;
        end else begin
            full     = (exp_q.size() == 16);
            exp_arr  = (!m_fv || arready_i) && !full;
            ar_acc   = arvalid_i && exp_arr;
            exp_awr  = !full && !ar_acc;
            aw_acc   = awvalid_i && exp_awr;
            exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;

            check("arready_o", EW'(arready_o), EW'(exp_arr));
            check("awready_o", EW'(awready_o), EW'(exp_awr));
            check("arvalid_o", EW'(arvalid_o), EW'(m_fv));
            check("arid_o",    EW'(arid_o),    EW'(m_id));
            check("araddr_o",  EW'(araddr_o),  EW'(m_addr));
            check("arlen_o",   EW'(arlen_o),   EW'(m_len));
            check("aempty_o",  EW'(aempty_o),  EW'(exp_q.size() == 0));
            check("data_o",    data_o,         exp_head);

            if (rden_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ar_acc) exp_q.push_back({1'b0, arid_i, araddr_i});
            else if (aw_acc) exp_q.push_back({1'b1, awid_i, awaddr_i});
            if (ar_acc) begin
                m_fv   = 1'b1;
                m_id   = arid_i;
                m_addr = araddr_i;
                m_len  = arlen_i;
            end else if (arready_i) begin
                m_fv = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arid_i = '0; araddr_i = '0; arlen_i = '0; arvalid_i = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awvalid_i = 1'b0;
        arready_i = 1'b0; rden_i = 1'b0;
    endtask

    task automatic drain();
        rden_i = 1'b1;
        repeat (20) tick();
        rden_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        check("rst arvalid_o", EW'(arvalid_o), '0);
        check("rst aempty_o",  EW'(aempty_o),  EW'(1));
        check("rst data_o",    data_o,         '0);
        check("rst arready_o", EW'(arready_o), EW'(1));
        check("rst awready_o", EW'(awready_o), EW'(1));
        tick();
        rst_n = 1'b0;

        // Single read
        arid_i = 16'd7; araddr_i = 64'heeee_eeee_eeee_eeee; arlen_i = 8'd10;
        arvalid_i = 1'b1; arready_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        @(negedge clk);
        check("rd arvalid_o", EW'(arvalid_o), EW'(1));
        check("rd arid_o",    EW'(arid_o),    EW'(16'h0007));
        check("rd araddr_o",  EW'(araddr_o),  EW'(64'heeee_eeee_eeee_eeee));
        check("rd arlen_o",   EW'(arlen_o),   EW'(8'h0a));
        check("rd aempty_o",  EW'(aempty_o),  '0);
        check("rd data_o",    data_o,         81'h0_0007_eeee_eeee_eeee_eeee);
        tick();
        @(negedge clk);
        check("rd arvalid_o drop", EW'(arvalid_o), '0);
        drain();

        // Backpressure on the forward register
        arready_i = 1'b0; arid_i = 16'd9; araddr_i = 64'h1234; arlen_i = 8'd3; arvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        tick();
        @(negedge clk);
        check("bp arvalid_o", EW'(arvalid_o), EW'(1));
        check("bp arid_o",    EW'(arid_o),    EW'(16'd9));
        check("bp arready_o", EW'(arready_o), '0);
        arready_i = 1'b1;
        tick();
        @(negedge clk);
        check("bp arvalid_o drop", EW'(arvalid_o), '0);
        drain();

        // Simultaneous read and write: read first, write next cycle
        arid_i = 16'd1; araddr_i = 64'h200; arvalid_i = 1'b1;
        awid_i = 16'd3; awaddr_i = 64'h100; awvalid_i = 1'b1;
        @(negedge clk);
        check("rw awready_o", EW'(awready_o), '0);
        tick();
        arvalid_i = 1'b0;
        tick();
        awvalid_i = 1'b0;
        @(negedge clk);
        check("rw head is read", EW'(data_o[80]), '0);
        rden_i = 1'b1;
        tick();
        rden_i = 1'b0;
        @(negedge clk);
        check("rw head is write", EW'(data_o[80]), EW'(1));
        check("rw write id",      EW'(data_o[79:64]), EW'(16'd3));
        drain();

        // Push and pop together at count 1
        awid_i = 16'h11; awaddr_i = 64'h40; awvalid_i = 1'b1;
        tick();
        awid_i = 16'h22; awaddr_i = 64'h80; rden_i = 1'b1;
        tick();
        awvalid_i = 1'b0; rden_i = 1'b0;
        @(negedge clk);
        check("pp aempty_o", EW'(aempty_o), '0);
        check("pp data_o",   data_o,        81'h1_0022_0000_0000_0000_0080);
        drain();

        // Fill to full, pop while full, then drain past empty
        awvalid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            awid_i = 16'(i); awaddr_i = 64'(i * 16);
            tick();
        end
        @(negedge clk);
        check("full arready_o", EW'(arready_o), '0);
        check("full awready_o", EW'(awready_o), '0);
        rden_i = 1'b1;
        tick();
        awvalid_i = 1'b0;
        repeat (20) tick();
        rden_i = 1'b0;
        @(negedge clk);
        check("drained aempty_o", EW'(aempty_o), EW'(1));
        check("drained data_o",   data_o,        '0);

        // Random traffic, with fill-heavy and drain-heavy phases and occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 399) == 0);
            arvalid_i = ($urandom_range(0, 9) < 4);
            awvalid_i = ($urandom_range(0, 9) < 4);
            arready_i = ($urandom_range(0, 9) < 6);
            rden_i    = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            arid_i    = 16'($urandom);
            araddr_i  = {$urandom, $urandom};
            arlen_i   = 8'($urandom);
            awid_i    = 16'($urandom);
            awaddr_i  = {$urandom, $urandom};
            awlen_i   = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        idle_inputs();
        tick();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
